// File: rtl/axi_wdata_router.sv
// W-channel router: forwards the queue-head master's write beats to the slave through a
// 2-entry registered skid buffer and pulses Write_Data_Finsh once the burst (part) drains.
module axi_wdata_router #(
    parameter int NUM_MASTERS = 2,
    parameter int ID_WIDTH    = 1,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                  ACLK,
    input  logic                                  ARESETN,
    input  logic                                  Master_Valid,
    input  logic [ID_WIDTH-1:0]                   Write_Data_Master,
    input  logic                                  Is_Master_Part_Of_Split,
    input  logic [8:0]                            Split_Beats,
    output logic                                  Write_Data_Finsh,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     S_WDATA,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   S_WSTRB,
    input  logic [NUM_MASTERS-1:0]                S_WLAST,
    input  logic [NUM_MASTERS-1:0]                S_WVALID,
    output logic [NUM_MASTERS-1:0]                S_WREADY,
    output logic [DATA_WIDTH-1:0]                 M_WDATA,
    output logic [DATA_WIDTH/8-1:0]               M_WSTRB,
    output logic                                  M_WLAST,
    output logic                                  M_WVALID,
    input  logic                                  M_WREADY
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int BW = DATA_WIDTH + SW + 1;
    localparam logic [ID_WIDTH:0] NM = NUM_MASTERS[ID_WIDTH:0];

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, POP} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] sel_q, sel_d;
    logic                split_q, split_d;
    logic [8:0]          limit_q, limit_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [1:0]          occ_q, occ_d;
    logic [BW-1:0]       ent0_q, ent0_d;
    logic [BW-1:0]       ent1_q, ent1_d;
    logic                finsh_q, finsh_d;

    logic [DATA_WIDTH-1:0] in_data;
    logic [SW-1:0]         in_strb;
    logic                  in_last, in_valid;
    logic                  s_ready, push, pop, beat_last, head_ok;
    logic [9:0]            cnt_inc;
    logic [BW-1:0]         push_word;

    always_comb begin
        in_data  = '0;
        in_strb  = '0;
        in_last  = 1'b0;
        in_valid = 1'b0;
        S_WREADY = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel_q == ID_WIDTH'(i)) begin
                in_data     = S_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
                in_strb     = S_WSTRB[i*SW +: SW];
                in_last     = S_WLAST[i];
                in_valid    = S_WVALID[i];
                S_WREADY[i] = s_ready;
            end
        end
    end

    // Readiness comes only from registered state and occupancy, never from M_WREADY.
    assign s_ready   = (state_q == ACTIVE) && (occ_q != 2'd2);
    assign push      = s_ready && in_valid;
    assign pop       = (occ_q != 2'd0) && M_WREADY;
    assign cnt_inc   = {1'b0, cnt_q} + 10'd1;
    assign beat_last = split_q ? (cnt_inc == {1'b0, limit_q}) : in_last;
    assign push_word = {beat_last, in_strb, in_data};
    assign head_ok   = {1'b0, Write_Data_Master} < NM;

    always_comb begin
        occ_d  = occ_q;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = push_word;
                else               ent1_d = push_word;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = push_word;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = push_word;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        split_d = split_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        finsh_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Master_Valid && head_ok) begin
                    state_d = ACTIVE;
                    sel_d   = Write_Data_Master;
                    split_d = Is_Master_Part_Of_Split;
                    limit_d = Split_Beats;
                    cnt_d   = '0;
                end
            end
            ACTIVE: begin
                if (push) begin
                    if (cnt_q != 9'h1ff) cnt_d = cnt_q + 9'd1;
                    if (beat_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Only the part-end beat carries WLAST, so its handshake closes the part.
                if (pop && ent0_q[BW-1]) begin
                    finsh_d = 1'b1;
                    state_d = POP;
                end
            end
            POP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            sel_q   <= '0;
            split_q <= 1'b0;
            limit_q <= '0;
            cnt_q   <= '0;
            occ_q   <= '0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            finsh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            split_q <= split_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
            occ_q   <= occ_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            finsh_q <= finsh_d;
        end
    end

    assign M_WDATA          = ent0_q[DATA_WIDTH-1:0];
    assign M_WSTRB          = ent0_q[DATA_WIDTH +: SW];
    assign M_WLAST          = ent0_q[BW-1];
    assign M_WVALID         = (occ_q != 2'd0);
    assign Write_Data_Finsh = finsh_q;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Randomized bench for axi_wdata_router: per-master beat streams and queue heads feed a
// reference model that derives the expected slave-side beat sequence from the routing rules.
module tb_axi_wdata_router;
    localparam int NM = 2;
    localparam int IW = 1;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct packed {logic [DW-1:0] d; logic [SW-1:0] s; logic l;} beat_t;
    typedef struct packed {int m; logic sp; logic [8:0] lim;} head_t;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic Master_Valid, Is_Master_Part_Of_Split, Write_Data_Finsh;
    logic [IW-1:0] Write_Data_Master;
    logic [8:0] Split_Beats;
    logic [NM*DW-1:0] S_WDATA;
    logic [NM*SW-1:0] S_WSTRB;
    logic [NM-1:0] S_WLAST, S_WVALID, S_WREADY;
    logic [DW-1:0] M_WDATA;
    logic [SW-1:0] M_WSTRB;
    logic M_WLAST, M_WVALID, M_WREADY;

    always #5 ACLK = ~ACLK;

    axi_wdata_router #(.NUM_MASTERS(NM), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .Master_Valid(Master_Valid),
        .Write_Data_Master(Write_Data_Master), .Is_Master_Part_Of_Split(Is_Master_Part_Of_Split),
        .Split_Beats(Split_Beats), .Write_Data_Finsh(Write_Data_Finsh),
        .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST), .S_WVALID(S_WVALID),
        .S_WREADY(S_WREADY), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
        .M_WVALID(M_WVALID), .M_WREADY(M_WREADY)
    );

    beat_t mq[NM][$];   // beats each master still has to send
    beat_t ms[NM][$];   // model copy, consumed when heads are queued
    head_t hq[$];
    beat_t eq[$];       // expected slave-side beats in order

    int n_chk = 0, n_pass = 0;
    int acc_n = 0, out_n = 0, fin_n = 0, h_n = 0;
    int cyc = 0, last_cyc = -100, fin_cyc = -100;
    int mv_pct = 100, sr_pct = 100, stall = 0;
    bit m_hs[NM];
    bit head_pop = 0, prev_stall = 0, prev_fin = 0;
    logic [DW+SW:0] prev_word;
    beat_t e;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic add_beats(input int m, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d = $urandom;
            b.s = SW'($urandom);
            b.l = (k == n - 1);
            mq[m].push_back(b);
            ms[m].push_back(b);
        end
    endtask

    // Split part: exactly lim beats, last forced on the lim-th; otherwise up to the master's WLAST.
    task automatic add_head(input int m, input bit sp, input int lim);
        beat_t b;
        hq.push_back('{m, sp, 9'(lim)});
        h_n++;
        if (sp) begin
            for (int k = 0; k < lim; k++) begin
                b = ms[m].pop_front();
                b.l = (k == lim - 1);
                eq.push_back(b);
            end
        end else begin
            do begin
                b = ms[m].pop_front();
                eq.push_back(b);
            end while (!b.l);
        end
    endtask

    task automatic burst(input int m, input int n);
        add_beats(m, n);
        add_head(m, 0, 0);
    endtask

    task automatic flush();
        for (int i = 0; i < NM; i++) begin
            mq[i].delete();
            ms[i].delete();
            m_hs[i] = 0;
        end
        hq.delete();
        eq.delete();
        head_pop = 0;
        acc_n = 0; out_n = 0; fin_n = 0; h_n = 0;
        prev_stall = 0; prev_fin = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(hq.size() == 0 && eq.size() == 0 && acc_n == out_n)) begin
            @(negedge ACLK);
            k++;
        end
        chk({tag, "_timeout"}, k < budget, 1);
        chk({tag, "_finsh_cnt"}, fin_n, h_n);
    endtask

    task automatic wait_out(input int target);
        int k;
        k = 0;
        while (k < 500 && out_n < target) begin
            @(negedge ACLK);
            k++;
        end
        chk("wait_out_timeout", k < 500, 1);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_mvalid"}, M_WVALID, 0);
        chk({tag, "_mlast"}, M_WLAST, 0);
        chk({tag, "_mdata"}, M_WDATA, 0);
        chk({tag, "_mstrb"}, M_WSTRB, 0);
        chk({tag, "_sready"}, S_WREADY, 0);
        chk({tag, "_finsh"}, Write_Data_Finsh, 0);
    endtask

    // Monitor: everything is sampled on the falling edge, well away from the active edge.
    initial forever begin
        @(negedge ACLK);
        cyc++;
        if (ARESETN) begin
            chk("mvalid_occ", M_WVALID, (acc_n - out_n) != 0);
            if (acc_n - out_n >= 2) chk("sready_full", |S_WREADY, 0);
            if (prev_stall) begin
                chk("stall_valid", M_WVALID, 1);
                chk("stall_word", {M_WLAST, M_WSTRB, M_WDATA}, prev_word);
            end
            prev_stall = M_WVALID && !M_WREADY;
            prev_word  = {M_WLAST, M_WSTRB, M_WDATA};
            if (M_WVALID && M_WREADY) begin
                out_n++;
                if (eq.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = eq.pop_front();
                    chk("wdata", M_WDATA, e.d);
                    chk("wstrb", M_WSTRB, e.s);
                    chk("wlast", M_WLAST, e.l);
                end
                if (M_WLAST) last_cyc = cyc;
            end
            if (Write_Data_Finsh) begin
                fin_n++;
                chk("finsh_lat", cyc - last_cyc, 1);
                chk("finsh_head", hq.size() != 0, 1);
                chk("finsh_single", prev_fin, 0);
                head_pop = 1;
                fin_cyc  = cyc;
            end
            prev_fin = Write_Data_Finsh;
            if (cyc == fin_cyc || cyc == fin_cyc + 1) chk("pop_gap_ready", |S_WREADY, 0);
            for (int i = 0; i < NM; i++) begin
                if (hq.size() == 0 || hq[0].m != i) chk("sready_other", S_WREADY[i], 0);
                if (S_WVALID[i] && S_WREADY[i]) begin
                    m_hs[i] = 1;
                    acc_n++;
                end
            end
        end
    end

    // Driver: masters, queue head and slave ready all change 1ns after the rising edge.
    initial forever begin
        @(posedge ACLK);
        #1;
        if (!ARESETN) begin
            S_WVALID = '0;
            Master_Valid = 1'b0;
        end else begin
            for (int i = 0; i < NM; i++) begin
                bit took;
                took = m_hs[i];
                if (m_hs[i] && mq[i].size() != 0) void'(mq[i].pop_front());
                m_hs[i] = 0;
                if (mq[i].size() == 0) S_WVALID[i] = 1'b0;
                else if (!S_WVALID[i] || took) S_WVALID[i] = ($urandom % 100) < mv_pct;
                if (mq[i].size() != 0) begin
                    S_WDATA[i*DW +: DW] = mq[i][0].d;
                    S_WSTRB[i*SW +: SW] = mq[i][0].s;
                    S_WLAST[i]          = mq[i][0].l;
                end
            end
            if (head_pop && hq.size() != 0) void'(hq.pop_front());
            head_pop = 0;
            Master_Valid = hq.size() != 0;
            if (hq.size() != 0) begin
                Write_Data_Master       = IW'(hq[0].m);
                Is_Master_Part_Of_Split = hq[0].sp;
                Split_Beats             = hq[0].lim;
            end
            if (stall > 0) begin
                M_WREADY = 1'b0;
                stall--;
            end else begin
                M_WREADY = ($urandom % 100) < sr_pct;
            end
        end
    end

    initial begin
        int m, n, lim;
        bit sp;
        Master_Valid = 0; Write_Data_Master = '0; Is_Master_Part_Of_Split = 0; Split_Beats = '0;
        S_WDATA = '0; S_WSTRB = '0; S_WLAST = '0; S_WVALID = '0; M_WREADY = 0;
        repeat (2) @(posedge ACLK);
        #1 rst_chk("reset");
        @(negedge ACLK) ARESETN = 1'b1;

        burst(0, 4);
        wait_done("m0_4beat", 200);

        burst(0, 8);
        wait_out(2);
        stall = 5;
        wait_done("stall", 300);

        add_beats(1, 8);
        add_head(1, 1, 3);
        add_head(1, 0, 0);
        wait_done("split", 300);

        burst(0, 5);
        burst(1, 3);
        wait_done("b2b", 300);

        // Master WLAST on beat 2 inside a 3-beat split part is plain data.
        add_beats(1, 2);
        add_beats(1, 3);
        add_head(1, 1, 3);
        add_head(1, 0, 0);
        wait_done("early_wlast", 300);

        burst(0, 4);
        wait_out(1);
        @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1 rst_chk("midrst");
        flush();
        repeat (3) @(posedge ACLK);
        @(negedge ACLK) ARESETN = 1'b1;
        burst(1, 4);
        wait_done("post_rst", 300);

        burst(0, 1);
        wait_done("single", 100);
        mv_pct = 90; sr_pct = 85;
        burst(1, 256);
        wait_done("b256", 2000);

        for (int t = 0; t < 20; t++) begin
            mv_pct = $urandom_range(50, 100);
            sr_pct = $urandom_range(40, 100);
            m   = $urandom % NM;
            n   = $urandom_range(1, 12);
            sp  = (n > 1) && ($urandom % 3 == 0);
            lim = sp ? $urandom_range(1, n - 1) : 0;
            add_beats(m, n);
            add_head(m, sp, lim);
            if (sp) add_head(m, 0, 0);
        end
        wait_done("random", 5000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
